// File: rtl/instr_mem_pkg.sv
// Shared sizing and loader FSM encoding for the instruction memory block.
package instr_mem_pkg;
  localparam int IM_DEPTH = 128;
  localparam int IM_AW    = 7;
  localparam int IM_DW    = 32;
  localparam int IM_LW    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } im_state_e;

  // Requests longer than the array would overwrite their own first words.
  function automatic logic [IM_LW-1:0] clamp_len(input logic [IM_LW-1:0] len);
    return (len > IM_LW'(IM_DEPTH)) ? IM_LW'(IM_DEPTH) : len;
  endfunction
endpackage

// File: rtl/instr_mem_resp_if.sv
// Fetch read port and program-load stream of the instruction memory.
interface instr_mem_resp_if;
  import instr_mem_pkg::*;

  logic             ena;
  logic [IM_AW-1:0] addra;
  logic [IM_DW-1:0] douta;
  logic             ld_start;
  logic [IM_AW-1:0] ld_base;
  logic [IM_LW-1:0] ld_len;
  logic             ld_valid;
  logic [IM_DW-1:0] ld_data;
  logic             ld_ready;
  logic             busy;
  logic             ld_done;
  logic             perr;

  modport slave (
    input  ena, addra, ld_start, ld_base, ld_len, ld_valid, ld_data,
    output douta, ld_ready, busy, ld_done, perr
  );

  modport master (
    output ena, addra, ld_start, ld_base, ld_len, ld_valid, ld_data,
    input  douta, ld_ready, busy, ld_done, perr
  );
endinterface

// File: rtl/instr_mem_resp_loader.sv
// Program-load sequencer (IDLE/LOAD/DONE): one word per ld_valid cycle, stalls
// without ld_valid, ld_done pulses for one cycle after the last write.
module im_loader
  import instr_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_start_i,
  input  logic [IM_AW-1:0] ld_base_i,
  input  logic [IM_LW-1:0] ld_len_i,
  input  logic             ld_valid_i,
  output logic             ld_ready_o,
  output logic             busy_o,
  output logic             ld_done_o,
  output logic             wr_en_o,
  output logic [IM_AW-1:0] wr_addr_o
);
  im_state_e        state_q, state_d;
  logic [IM_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IM_LW-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ld_ready_o = 1'b0;
    busy_o     = 1'b0;
    ld_done_o  = 1'b0;
    wr_en_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_start_i && (ld_len_i != '0)) begin
          state_d  = LOAD;
          wr_ptr_d = ld_base_i;
          count_d  = clamp_len(ld_len_i);
        end
      end
      LOAD: begin
        ld_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (ld_valid_i) begin
          // Reset wins over a word presented in the same cycle.
          wr_en_o  = ~rst;
          wr_ptr_d = wr_ptr_q + IM_AW'(1);
          count_d  = count_q - IM_LW'(1);
          if (count_q == IM_LW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        ld_done_o = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_addr_o = wr_ptr_q;
endmodule

// File: rtl/instr_mem_resp.sv
// 128x32 instruction memory, 1-cycle registered read, reads blocked during a load.
// Optional IM_PARITY_EN stores an even-parity bit per word and flags mismatches on perr.
module instr_mem_resp
  import instr_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  instr_mem_resp_if.slave   bus
);
`ifdef IM_PARITY_EN
  localparam int MW = IM_DW + 1;
`else
  localparam int MW = IM_DW;
`endif

  logic [MW-1:0]    mem_q [IM_DEPTH];
  logic [MW-1:0]    wr_word;
  logic [MW-1:0]    rd_word;
  logic [IM_DW-1:0] douta_q;
  logic             wr_en;
  logic [IM_AW-1:0] wr_addr;
  logic             busy;
  logic             rd_en;

  im_loader u_loader (
    .clk        (clk),
    .rst        (rst),
    .ld_start_i (bus.ld_start),
    .ld_base_i  (bus.ld_base),
    .ld_len_i   (bus.ld_len),
    .ld_valid_i (bus.ld_valid),
    .ld_ready_o (bus.ld_ready),
    .busy_o     (busy),
    .ld_done_o  (bus.ld_done),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr)
  );

`ifdef IM_PARITY_EN
  assign wr_word = {^bus.ld_data, bus.ld_data};
`else
  assign wr_word = bus.ld_data;
`endif

  // Storage is deliberately outside reset so a load survives an aborting rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_word;
    end
  end

  assign rd_word = mem_q[bus.addra];
  assign rd_en   = bus.ena & ~busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      douta_q <= '0;
    end else if (rd_en) begin
      douta_q <= rd_word[IM_DW-1:0];
    end
  end

`ifdef IM_PARITY_EN
  logic perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else if (rd_en) begin
      perr_q <= ^rd_word;
    end
  end

  assign bus.perr = perr_q;
`else
  assign bus.perr = 1'b0;
`endif

  assign bus.douta = douta_q;
  assign bus.busy  = busy;
endmodule
